// File: rtl/tdc_hw_stats_pkg.sv
// Shared types and constants for the TDC Hamming-weight statistics engine.
package tdc_hw_stats_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] RD_MEAN = 2'd0;
  localparam logic [1:0] RD_MIN  = 2'd1;
  localparam logic [1:0] RD_MAX  = 2'd2;
  localparam logic [1:0] RD_SAT  = 2'd3;

  localparam int         HW_W_DEF    = 7;
  localparam logic [6:0] HW_MAX      = 7'd127;
  localparam logic [7:0] SAT_CNT_MAX = 8'd255;

  // Readout multiplexer over the four zero-extended results.
  function automatic logic [7:0] rd_pick(input logic [1:0] sel,
                                         input logic [7:0] mean,
                                         input logic [7:0] min_v,
                                         input logic [7:0] max_v,
                                         input logic [7:0] sat);
    logic [7:0] r;
    case (sel)
      RD_MEAN: r = mean;
      RD_MIN:  r = min_v;
      RD_MAX:  r = max_v;
      RD_SAT:  r = sat;
      default: r = 8'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tdc_hw_stats.sv
// Windowed min/max/mean/saturation statistics over 2^LOG2_N valid TDC
// Hamming-weight samples, frozen for slow readout through an 8-bit port.
module tdc_hw_stats
  import tdc_hw_stats_pkg::*;
#(
  parameter int HW_W   = 7,
  parameter int LOG2_N = 8,
  parameter int SUM_W  = HW_W + LOG2_N
) (
  input  logic            clk_launch,
  input  logic            rst_n,
  input  logic            start,
  input  logic            hw_valid,
  input  logic [HW_W-1:0] hw,
  input  logic [1:0]      rd_sel,
  input  logic            rd_ack,
  output logic            busy,
  output logic            done,
  output logic [7:0]      rd_data
);

  localparam logic [HW_W-1:0]   HW_TOP   = {HW_W{1'b1}};
  localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};

  state_e            state_r;
  logic [HW_W-1:0]   hw_q_r;
  logic              valid_q_r;
  logic [SUM_W-1:0]  sum_r;
  logic [LOG2_N-1:0] cnt_r;
  logic [HW_W-1:0]   min_r;
  logic [HW_W-1:0]   max_r;
  logic [7:0]        sat_r;
  logic              busy_r;
  logic              done_r;
  logic [7:0]        rd_data_r;

  logic              acc_en_s;
  logic              last_s;
  logic [SUM_W-1:0]  sum_nx_s;
  logic [HW_W-1:0]   min_nx_s;
  logic [HW_W-1:0]   max_nx_s;
  logic [7:0]        sat_nx_s;
  logic [7:0]        mean8_s;
  logic [7:0]        min8_s;
  logic [7:0]        max8_s;
  logic [7:0]        rd_mux_s;

  // Next-value datapath; the mux sees post-update values so rd_data is
  // already valid on the edge that enters DONE.
  always_comb begin
    acc_en_s = (state_r == ACCUM) && valid_q_r;
    last_s   = acc_en_s && (cnt_r == CNT_LAST);
    sum_nx_s = acc_en_s ? (sum_r + {{LOG2_N{1'b0}}, hw_q_r}) : sum_r;
    min_nx_s = (acc_en_s && (hw_q_r < min_r)) ? hw_q_r : min_r;
    max_nx_s = (acc_en_s && (hw_q_r > max_r)) ? hw_q_r : max_r;
    sat_nx_s = (acc_en_s && ((hw_q_r == {HW_W{1'b0}}) || (hw_q_r == HW_TOP))
                && (sat_r != SAT_CNT_MAX)) ? (sat_r + 8'd1) : sat_r;
    mean8_s  = 8'd0;
    min8_s   = 8'd0;
    max8_s   = 8'd0;
    mean8_s[HW_W-1:0] = sum_nx_s[SUM_W-1:LOG2_N];
    min8_s[HW_W-1:0]  = min_nx_s;
    max8_s[HW_W-1:0]  = max_nx_s;
    rd_mux_s = rd_pick(rd_sel, mean8_s, min8_s, max8_s, sat_nx_s);
  end

  // Control FSM, input stage, statistics registers and registered outputs.
  always_ff @(posedge clk_launch) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      hw_q_r    <= {HW_W{1'b0}};
      valid_q_r <= 1'b0;
      sum_r     <= {SUM_W{1'b0}};
      cnt_r     <= {LOG2_N{1'b0}};
      min_r     <= HW_TOP;
      max_r     <= {HW_W{1'b0}};
      sat_r     <= 8'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rd_data_r <= 8'd0;
    end else if (start) begin
      // start wins in every state and also drops the sample in flight
      state_r   <= ACCUM;
      hw_q_r    <= {HW_W{1'b0}};
      valid_q_r <= 1'b0;
      sum_r     <= {SUM_W{1'b0}};
      cnt_r     <= {LOG2_N{1'b0}};
      min_r     <= HW_TOP;
      max_r     <= {HW_W{1'b0}};
      sat_r     <= 8'd0;
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
      rd_data_r <= 8'd0;
    end else begin
      hw_q_r    <= hw;
      valid_q_r <= hw_valid;
      case (state_r)
        IDLE: begin
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          rd_data_r <= 8'd0;
        end
        ACCUM: begin
          rd_data_r <= 8'd0;
          if (acc_en_s) begin
            sum_r <= sum_nx_s;
            min_r <= min_nx_s;
            max_r <= max_nx_s;
            sat_r <= sat_nx_s;
            cnt_r <= cnt_r + {{(LOG2_N-1){1'b0}}, 1'b1};
          end else begin
            cnt_r <= cnt_r;
          end
          if (last_s) begin
            state_r   <= DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            rd_data_r <= rd_mux_s;
          end else begin
            busy_r    <= 1'b1;
          end
        end
        DONE: begin
          if (rd_ack) begin
            state_r   <= IDLE;
            done_r    <= 1'b0;
            rd_data_r <= 8'd0;
          end else begin
            rd_data_r <= rd_mux_s;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          rd_data_r <= 8'd0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign rd_data = rd_data_r;

endmodule
